// File: rtl/risc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// risc_ctrl_pkg
// Shared definitions for the RiSC-16 multi-cycle control unit: word and
// ALU-function widths, opcodes, FSM state encoding, datapath select
// encodings and the decoded-instruction record passed from the decoder
// to the sequencer.
// ---------------------------------------------------------------------------
package risc_ctrl_pkg;

    localparam int WORD_LEN  = 16;
    localparam int FUNCT_LEN = 1;

    localparam logic [FUNCT_LEN-1:0] FUNCT_ADD  = 1'b0;
    localparam logic [FUNCT_LEN-1:0] FUNCT_NAND = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] PCSEL_INC    = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_REG    = 2'd2;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_LUI = 2'd2;
    localparam logic [1:0] WSEL_PC  = 2'd3;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

    // Everything the sequencer needs to know about the instruction in IR.
    typedef struct packed {
        logic [FUNCT_LEN-1:0] alu_funct;
        logic                 alu_srcb_sel;
        logic [1:0]           wb_sel;
        logic [2:0]           ra1;
        logic [2:0]           ra2;
        logic [2:0]           wa;
        logic                 is_mem;
        logic                 is_sw;
        logic                 is_beq;
        logic                 is_jalr;
        logic                 is_halt;
    } decode_t;

endpackage

// File: rtl/risc_ctrl_if.sv
// ---------------------------------------------------------------------------
// risc_ctrl_if
// Ready-handshaked memory port between the control unit and memory.
//   mem_req   : request pending (held until an edge with mem_ready=1)
//   mem_we    : pending request is a write
//   mem_rdata : read data returned by memory
//   mem_ready : memory completes the pending request at this edge
// master = control unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface risc_ctrl_if;
    import risc_ctrl_pkg::*;

    logic                mem_req;
    logic                mem_we;
    logic [WORD_LEN-1:0] mem_rdata;
    logic                mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/risc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// risc_decode
// Purely combinational decoder from the instruction register to register
// addresses, ALU function/operand select, write-back source and the
// instruction-class flags used by the sequencer.
//   ir  : current instruction
//   dec : decoded fields (see decode_t)
// ---------------------------------------------------------------------------
module risc_decode
    import risc_ctrl_pkg::*;
#(
    parameter bit ALLOW_HALT = 1'b1
) (
    input  logic [WORD_LEN-1:0] ir,
    output decode_t             dec
);

    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rc;

    assign ra = ir[12:10];
    assign rb = ir[9:7];
    assign rc = ir[2:0];

    // Read port 2 carries rA for everything except the register-register
    // ALU ops; that is what SW stores and what BEQ compares against.
    always_comb begin
        dec              = '0;
        dec.alu_funct    = FUNCT_ADD;
        dec.alu_srcb_sel = 1'b0;
        dec.wb_sel       = WSEL_ALU;
        dec.ra1          = rb;
        dec.ra2          = ra;
        dec.wa           = ra;
        case (ir[15:13])
            OP_ADD: begin
                dec.ra2 = rc;
            end
            OP_ADDI: begin
                dec.alu_srcb_sel = 1'b1;
            end
            OP_NAND: begin
                dec.alu_funct = FUNCT_NAND;
                dec.ra2       = rc;
            end
            OP_LUI: begin
                dec.wb_sel = WSEL_LUI;
            end
            OP_SW: begin
                dec.alu_srcb_sel = 1'b1;
                dec.is_mem       = 1'b1;
                dec.is_sw        = 1'b1;
            end
            OP_LW: begin
                dec.alu_srcb_sel = 1'b1;
                dec.is_mem       = 1'b1;
                dec.wb_sel       = WSEL_MEM;
            end
            OP_BEQ: begin
                dec.is_beq = 1'b1;
            end
            OP_JALR: begin
                dec.is_jalr = 1'b1;
                // A JALR with a nonzero immediate is the halt encoding.
                dec.is_halt = ALLOW_HALT && (ir[6:0] != 7'd0);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/risc_ctrl.sv
// ---------------------------------------------------------------------------
// risc_ctrl
// Multi-cycle control unit for the non-pipelined RiSC-16 core. Holds the
// instruction register and sequences FETCH/DECODE/EXEC/MEM/WB/HALT.
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   bus          : memory handshake port (master side)
//   rf_eq        : datapath comparator, read port 1 == read port 2
//   ir           : current instruction
//   addr_sel     : memory address source (PC / ALU out)
//   pc_en/pc_sel : PC load enable and source
//   alu_funct    : ALU function, alu_srcb_sel : ALU operand B source
//   rf_ra1/ra2/wa: register addresses, rf_we/rf_wsel : write enable/source
//   halted       : core is stopped
// ---------------------------------------------------------------------------
module risc_ctrl
    import risc_ctrl_pkg::*;
#(
    parameter bit ALLOW_HALT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    risc_ctrl_if.master          bus,
    input  logic                 rf_eq,
    output logic [WORD_LEN-1:0]  ir,
    output logic                 addr_sel,
    output logic                 pc_en,
    output logic [1:0]           pc_sel,
    output logic [FUNCT_LEN-1:0] alu_funct,
    output logic                 alu_srcb_sel,
    output logic [2:0]           rf_ra1,
    output logic [2:0]           rf_ra2,
    output logic [2:0]           rf_wa,
    output logic                 rf_we,
    output logic [1:0]           rf_wsel,
    output logic                 halted
);

    state_t              state_q;
    state_t              state_d;
    logic [WORD_LEN-1:0] ir_q;
    decode_t             dec;
    logic                we_raw;
    logic                req_c;
    logic                mem_we_c;

    risc_decode #(
        .ALLOW_HALT(ALLOW_HALT)
    ) u_decode (
        .ir (ir_q),
        .dec(dec)
    );

    // State register and IR; IR only loads on the edge that completes a fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_FETCH && bus.mem_ready) begin
                ir_q <= bus.mem_rdata;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = dec.is_halt ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (dec.is_mem) begin
                    state_d = ST_MEM;
                end else if (dec.is_beq || dec.is_jalr) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    state_d = dec.is_sw ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Output decode. Everything is forced low while rst is high, even
    // though the state register already sits in FETCH, so that a reset in
    // the middle of an access withdraws the request at once.
    // In FETCH, pc_en follows mem_ready so the PC advances only on the
    // edge that actually returns the instruction, not on every wait cycle.
    always_comb begin
        req_c        = 1'b0;
        mem_we_c     = 1'b0;
        addr_sel     = ADDR_PC;
        pc_en        = 1'b0;
        pc_sel       = PCSEL_INC;
        alu_funct    = FUNCT_ADD;
        alu_srcb_sel = 1'b0;
        we_raw       = 1'b0;
        rf_wsel      = WSEL_ALU;
        halted       = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    req_c    = 1'b1;
                    addr_sel = ADDR_PC;
                    pc_en    = bus.mem_ready;
                    pc_sel   = PCSEL_INC;
                end
                ST_DECODE: begin
                end
                ST_EXEC: begin
                    alu_funct    = dec.alu_funct;
                    alu_srcb_sel = dec.alu_srcb_sel;
                    if (dec.is_beq) begin
                        pc_sel = PCSEL_BRANCH;
                        pc_en  = rf_eq;
                    end
                    if (dec.is_jalr) begin
                        we_raw  = 1'b1;
                        rf_wsel = WSEL_PC;
                        pc_en   = 1'b1;
                        pc_sel  = PCSEL_REG;
                    end
                end
                ST_MEM: begin
                    req_c        = 1'b1;
                    addr_sel     = ADDR_ALU;
                    mem_we_c     = dec.is_sw;
                    alu_funct    = dec.alu_funct;
                    alu_srcb_sel = dec.alu_srcb_sel;
                end
                ST_WB: begin
                    we_raw       = 1'b1;
                    rf_wsel      = dec.wb_sel;
                    alu_funct    = dec.alu_funct;
                    alu_srcb_sel = dec.alu_srcb_sel;
                end
                ST_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // r0 is hardwired to zero, so writes addressed to it are suppressed.
    assign rf_we       = we_raw && (dec.wa != 3'd0);
    assign rf_ra1      = dec.ra1;
    assign rf_ra2      = dec.ra2;
    assign rf_wa       = dec.wa;
    assign ir          = ir_q;
    assign bus.mem_req = req_c;
    assign bus.mem_we  = mem_we_c;

endmodule

// File: tb/tb_risc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_risc_ctrl
// Self-checking bench for risc_ctrl: a table of single instructions run
// through a bench-side memory with programmable wait states, plus directed
// sequences for fetch waits, halt and reset during a store.
// ---------------------------------------------------------------------------
module tb_risc_ctrl;
    import risc_ctrl_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 rf_eq;
    logic [WORD_LEN-1:0]  ir;
    logic                 addr_sel;
    logic                 pc_en;
    logic [1:0]           pc_sel;
    logic [FUNCT_LEN-1:0] alu_funct;
    logic                 alu_srcb_sel;
    logic [2:0]           rf_ra1;
    logic [2:0]           rf_ra2;
    logic [2:0]           rf_wa;
    logic                 rf_we;
    logic [1:0]           rf_wsel;
    logic                 halted;

    int compared;
    int mismatched;

    risc_ctrl_if bus ();

    risc_ctrl #(
        .ALLOW_HALT(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rf_eq       (rf_eq),
        .ir          (ir),
        .addr_sel    (addr_sel),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .alu_funct   (alu_funct),
        .alu_srcb_sel(alu_srcb_sel),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_wa       (rf_wa),
        .rf_we       (rf_we),
        .rf_wsel     (rf_wsel),
        .halted      (halted)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       we;
        logic [1:0] wsel;
        logic       pcen;
        logic [1:0] pcsel;
        logic       memwe;
        logic       funct;
        logic       srcb;
        logic [2:0] wa;
        logic [2:0] ra1;
        logic [2:0] ra2;
    } out_t;

    typedef struct {
        logic [15:0] instr;
        logic        eq;
        int          waits;
        int          exp_cycles;
        int          exp_mem;
        out_t        exp_out;
    } vec_t;

    function automatic out_t mkOut(input logic we, input logic [1:0] wsel,
                                   input logic pcen, input logic [1:0] pcsel,
                                   input logic memwe, input logic funct,
                                   input logic srcb, input logic [2:0] wa,
                                   input logic [2:0] ra1, input logic [2:0] ra2);
        out_t o;
        o.we = we; o.wsel = wsel; o.pcen = pcen; o.pcsel = pcsel;
        o.memwe = memwe; o.funct = funct; o.srcb = srcb;
        o.wa = wa; o.ra1 = ra1; o.ra2 = ra2;
        return o;
    endfunction

    function automatic out_t snap();
        out_t o;
        o.we = rf_we; o.wsel = rf_wsel; o.pcen = pc_en; o.pcsel = pc_sel;
        o.memwe = bus.mem_we; o.funct = alu_funct[0]; o.srcb = alu_srcb_sel;
        o.wa = rf_wa; o.ra1 = rf_ra1; o.ra2 = rf_ra2;
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one instruction from a FETCH cycle until the FSM returns to FETCH
    // (or halts). Memory stalls the first `waits` data-access cycles.
    // Returns the cycle count, data-access cycles and the final-cycle outputs.
    task automatic applyStimulus(input logic [15:0] instr, input logic eq,
                                 input int waits, output int cycles,
                                 output int mem_cycles, output out_t last,
                                 output logic [15:0] last_ir);
        int left;
        left       = waits;
        cycles     = 0;
        mem_cycles = 0;
        last       = '0;
        last_ir    = '0;
        bus.mem_rdata = instr;
        rf_eq         = eq;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.mem_req && addr_sel && left > 0) begin
                bus.mem_ready = 1'b0;
                left--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            last    = snap();
            last_ir = ir;
            cycles++;
            if (bus.mem_req && addr_sel) mem_cycles++;
            @(posedge clk);
            #1;
            if ((bus.mem_req && !addr_sel) || halted) break;
        end
    endtask

    logic [WORD_LEN+22:0] all_out;
    assign all_out = {bus.mem_req, bus.mem_we, addr_sel, halted, ir, snap()};

    vec_t        vecs[12];
    int          cyc;
    int          memc;
    out_t        got;
    logic [15:0] got_ir;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst           = 1'b1;
        rf_eq         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h0503;

        vecs[0]  = '{16'h0503, 1'b0, 0, 4, 0, mkOut(1, 0, 0, 0, 0, 0, 0, 1, 2, 3)};
        vecs[1]  = '{16'h4503, 1'b0, 0, 4, 0, mkOut(1, 0, 0, 0, 0, 1, 0, 1, 2, 3)};
        vecs[2]  = '{16'h257F, 1'b0, 0, 4, 0, mkOut(1, 0, 0, 0, 0, 0, 1, 1, 2, 1)};
        vecs[3]  = '{16'h6D55, 1'b0, 0, 4, 0, mkOut(1, 2, 0, 0, 0, 0, 0, 3, 2, 3)};
        vecs[4]  = '{16'h92FF, 1'b0, 0, 4, 1, mkOut(0, 0, 0, 0, 1, 0, 1, 4, 5, 4)};
        vecs[5]  = '{16'hB2FF, 1'b0, 2, 7, 3, mkOut(1, 1, 0, 0, 0, 0, 1, 4, 5, 4)};
        vecs[6]  = '{16'hB2FF, 1'b0, 0, 5, 1, mkOut(1, 1, 0, 0, 0, 0, 1, 4, 5, 4)};
        vecs[7]  = '{16'hC503, 1'b1, 0, 3, 0, mkOut(0, 0, 1, 1, 0, 0, 0, 1, 2, 1)};
        vecs[8]  = '{16'hC503, 1'b0, 0, 3, 0, mkOut(0, 0, 0, 1, 0, 0, 0, 1, 2, 1)};
        vecs[9]  = '{16'hFC80, 1'b0, 0, 3, 0, mkOut(1, 3, 1, 2, 0, 0, 0, 7, 1, 7)};
        vecs[10] = '{16'h0102, 1'b0, 0, 4, 0, mkOut(0, 0, 0, 0, 0, 0, 0, 0, 2, 2)};
        vecs[11] = '{16'h92FF, 1'b0, 1, 5, 2, mkOut(0, 0, 0, 0, 1, 0, 1, 4, 5, 4)};

        // Reset state: every output low even with memory ready.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", all_out, '0);
        rst = 1'b0;
        #1;
        checkOutput("first_fetch", {bus.mem_req, addr_sel, halted}, 3'b100);

        // Fetch with one wait cycle: request held, PC only pulses on ready.
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0503;
        @(negedge clk); #1;
        checkOutput("fetch_wait", {bus.mem_req, addr_sel, pc_en}, 3'b100);
        @(posedge clk); #1;
        checkOutput("fetch_hold", {bus.mem_req, addr_sel, ir}, {2'b10, 16'h0000});
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("fetch_ready_pc", {pc_en, pc_sel}, 3'b100);
        @(posedge clk); #1;
        checkOutput("decode_ir", {bus.mem_req, pc_en, rf_we, ir}, {3'b000, 16'h0503});
        repeat (3) @(posedge clk);
        #1;
        checkOutput("back_to_fetch", {bus.mem_req, addr_sel}, 2'b10);

        // Instruction table.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].instr, vecs[i].eq, vecs[i].waits, cyc, memc, got, got_ir);
            checkOutput($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cycles);
            checkOutput($sformatf("v%0d_mem_cycles", i), memc, vecs[i].exp_mem);
            checkOutput($sformatf("v%0d_outputs", i), got, vecs[i].exp_out);
            checkOutput($sformatf("v%0d_ir", i), got_ir, vecs[i].instr);
        end

        // Reset asserted while a store waits in MEM.
        bus.mem_rdata = 16'h92FF;
        bus.mem_ready = 1'b1;
        rf_eq         = 1'b0;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("sw_mem_wait", {bus.mem_req, bus.mem_we, addr_sel}, 3'b111);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("sw_reset_outputs", all_out, '0);
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("sw_reset_hold", {bus.mem_req, bus.mem_we, ir}, '0);
        rst = 1'b0;
        #1;
        checkOutput("sw_reset_resume", {bus.mem_req, bus.mem_we, addr_sel, ir}, {3'b100, 16'h0000});

        // Halting JALR: stops after DECODE, only reset restarts.
        applyStimulus(16'hE001, 1'b0, 0, cyc, memc, got, got_ir);
        checkOutput("halt_cycles", cyc, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checkOutput($sformatf("halt_idle%0d", k),
                        {bus.mem_req, bus.mem_we, pc_en, rf_we, halted}, 5'b00001);
        end
        rst = 1'b1;
        #1;
        checkOutput("halt_reset_outputs", all_out, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("halt_restart", {bus.mem_req, addr_sel, halted}, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
